// File: rtl/dm_cache.sv
// Direct-mapped, line-refilled cache with no write-allocate.
// A refill streams one beat per cycle and pushes out the evicted line word by word on DOut.
module dm_cache #(
  parameter int DataWidth   = 32,
  parameter int LogLineSize = 4,
  parameter int Capacity    = 1024,
  parameter int AddrWidth   = 32
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Enable,
  input  logic [1:0]           Cmd,
  input  logic [AddrWidth-1:0] Addr,
  input  logic [DataWidth-1:0] DIn,
  output logic                 Hit,
  output logic [DataWidth-1:0] DOut,
  output logic                 Ready,
  output logic                 EvictValid
);
  localparam int Lines = Capacity >> LogLineSize;
  localparam int IdxW  = $clog2(Lines);
  localparam int TagW  = AddrWidth - LogLineSize - IdxW;
  localparam int MemAW = IdxW + LogLineSize;

  localparam logic [1:0] CmdRead   = 2'd0;
  localparam logic [1:0] CmdWrite  = 2'd1;
  localparam logic [1:0] CmdRefill = 2'd2;

  typedef enum logic {S_IDLE, S_FILL} state_e;

  state_e                 state_q, state_d;
  logic [DataWidth-1:0]   mem [Capacity];
  logic [TagW-1:0]        tags [Lines];
  logic [Lines-1:0]       valid;
  logic [LogLineSize-1:0] cnt;
  logic [IdxW-1:0]        fidx;
  logic [TagW-1:0]        ftag;
  logic                   fevict;

  logic [LogLineSize-1:0] off;
  logic [IdxW-1:0]        idx;
  logic [TagW-1:0]        tg;
  logic                   acc, hit_c, evict_c, mem_we;
  logic [MemAW-1:0]       mem_a;

  assign off     = Addr[LogLineSize-1:0];
  assign idx     = Addr[LogLineSize +: IdxW];
  assign tg      = Addr[AddrWidth-1 -: TagW];
  assign acc     = Enable && Ready;
  assign hit_c   = valid[idx] && (tags[idx] == tg);
  assign evict_c = valid[idx] && (tags[idx] != tg);

  // mem_a doubles as the read address so the evicted word is read before being overwritten
  always_comb begin
    state_d = state_q;
    mem_we  = 1'b0;
    mem_a   = {idx, off};
    case (state_q)
      S_IDLE: if (acc) begin
        if (Cmd == CmdRefill) begin
          state_d = S_FILL;
          mem_we  = 1'b1;
          mem_a   = {idx, {LogLineSize{1'b0}}};
        end else if (Cmd == CmdWrite && hit_c) begin
          mem_we  = 1'b1;
        end
      end
      S_FILL: begin
        mem_we = 1'b1;
        mem_a  = {fidx, cnt};
        if (cnt == '1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (mem_we) mem[mem_a] <= DIn;
  end

  always_ff @(posedge Clock) begin
    if (state_q == S_FILL && cnt == '1) tags[fidx] <= ftag;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      Ready      <= 1'b1;
      Hit        <= 1'b0;
      EvictValid <= 1'b0;
      DOut       <= '0;
      valid      <= '0;
      cnt        <= '0;
      fidx       <= '0;
      ftag       <= '0;
      fevict     <= 1'b0;
    end else begin
      state_q    <= state_d;
      Ready      <= (state_d == S_IDLE);
      Hit        <= 1'b0;
      EvictValid <= 1'b0;
      case (state_q)
        S_IDLE: if (acc) begin
          if (Cmd == CmdRead) begin
            Hit  <= hit_c;
            DOut <= mem[mem_a];
          end else if (Cmd == CmdWrite) begin
            Hit  <= hit_c;
          end else if (Cmd == CmdRefill) begin
            fidx       <= idx;
            ftag       <= tg;
            fevict     <= evict_c;
            EvictValid <= evict_c;
            DOut       <= mem[mem_a];
            cnt        <= LogLineSize'(1);
          end
        end
        S_FILL: begin
          EvictValid <= fevict;
          DOut       <= mem[mem_a];
          cnt        <= cnt + 1'b1;
          if (cnt == '1) valid[fidx] <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_cache.sv
// Directed bench for dm_cache (4 lines of 16 words): fills, hits, write-through,
// eviction streaming, idle/no-op behaviour and reset abort during a refill.
module tb_dm_cache;
  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Enable = 1'b0;
  logic [1:0]  Cmd = 2'd0;
  logic [31:0] Addr = '0;
  logic [31:0] DIn = '0;
  logic        Hit;
  logic [31:0] DOut;
  logic        Ready;
  logic        EvictValid;

  int compared = 0;
  int mismatched = 0;

  dm_cache #(.DataWidth(32), .LogLineSize(4), .Capacity(64), .AddrWidth(32)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Cmd(Cmd), .Addr(Addr), .DIn(DIn),
    .Hit(Hit), .DOut(DOut), .Ready(Ready), .EvictValid(EvictValid)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  // drive one cycle, then sample 1 time unit after the edge
  task automatic step(input logic en, input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
    Enable = en; Cmd = c; Addr = a; DIn = d;
    @(posedge Clock); #1;
  endtask

  initial begin
    logic [31:0] old_word;
    @(posedge Clock); #1;
    chk("rst_ready", Ready, 1); chk("rst_hit", Hit, 0);
    chk("rst_ev", EvictValid, 0); chk("rst_dout", DOut, 0);
    @(posedge Clock); #1;
    Reset = 1'b1;

    // cold read misses
    step(1, 0, 5, 0);
    chk("cold_hit", Hit, 0); chk("cold_ready", Ready, 1); chk("cold_ev", EvictValid, 0);

    // refill line 0 with 100*k; Enable/Cmd are ignored on beats 1..15
    step(1, 2, 0, 0);
    chk("fill0_ready_b0", Ready, 0); chk("fill0_ev_b0", EvictValid, 0); chk("fill0_hit_b0", Hit, 0);
    for (int k = 1; k < 16; k++) begin
      step(k[0], 2'(k), 32'(k * 7), 32'(100 * k));
      chk($sformatf("fill0_ready_b%0d", k), Ready, (k == 15) ? 1 : 0);
      chk($sformatf("fill0_ev_b%0d", k), EvictValid, 0);
      chk($sformatf("fill0_hit_b%0d", k), Hit, 0);
    end
    step(1, 0, 3, 0);
    chk("rd3_hit", Hit, 1); chk("rd3_dout", DOut, 300);

    // write hit, write miss (no allocate)
    step(1, 1, 3, 7);
    chk("wr3_hit", Hit, 1);
    step(1, 0, 3, 0);
    chk("rd3b_hit", Hit, 1); chk("rd3b_dout", DOut, 7);
    step(1, 1, 67, 99);
    chk("wr67_hit", Hit, 0);
    step(1, 0, 3, 0);
    chk("rd3c_dout", DOut, 7);

    // refill 64 evicts old line 0 word by word
    for (int k = 0; k < 16; k++) begin
      step((k == 0) ? 1'b1 : 1'b0, 2, 64, 32'(1000 + k));
      old_word = (k == 3) ? 32'd7 : 32'(100 * k);
      chk($sformatf("evict_v_b%0d", k), EvictValid, 1);
      chk($sformatf("evict_d_b%0d", k), DOut, old_word);
      chk($sformatf("evict_ready_b%0d", k), Ready, (k == 15) ? 1 : 0);
    end
    step(1, 0, 0, 0);
    chk("rd0_hit", Hit, 0); chk("rd0_ev", EvictValid, 0);
    step(1, 0, 65, 0);
    chk("rd65_hit", Hit, 1); chk("rd65_dout", DOut, 1001);

    // disabled write and reserved command
    step(0, 1, 65, 555);
    chk("dis_hit", Hit, 0); chk("dis_ev", EvictValid, 0);
    step(1, 0, 65, 0);
    chk("dis_rd_dout", DOut, 1001);
    step(1, 3, 65, 9);
    chk("nop_hit", Hit, 0); chk("nop_ready", Ready, 1); chk("nop_ev", EvictValid, 0);
    step(1, 0, 65, 0);
    chk("nop_rd_dout", DOut, 1001);

    // same-tag refill: no eviction
    for (int k = 0; k < 16; k++) begin
      step(1, 2, 64, 32'(2000 + k));
      chk($sformatf("same_ev_b%0d", k), EvictValid, 0);
    end
    step(1, 0, 65, 0);
    chk("same_rd_hit", Hit, 1); chk("same_rd_dout", DOut, 2001);

    // reset during beat 5 of a refill
    for (int k = 0; k < 5; k++) step((k == 0) ? 1'b1 : 1'b0, 2, 64, 32'(3000 + k));
    chk("abort_ready_pre", Ready, 0);
    DIn = 3005;
    Reset = 1'b0;
    #1;
    chk("abort_ready", Ready, 1); chk("abort_ev", EvictValid, 0);
    chk("abort_hit", Hit, 0); chk("abort_dout", DOut, 0);
    @(posedge Clock); #1;
    Reset = 1'b1;
    step(1, 0, 64, 0);
    chk("abort_rd64_hit", Hit, 0); chk("abort_rd64_ready", Ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
